// File: rtl/scan_seq_ctrl.sv
// Scan-chain test sequencer: one command per handshake runs an optional pattern shift-in,
// N functional cycles and an optional shift-out, then returns the captured chain value.
module scan_seq_ctrl #(
    parameter int unsigned CHAIN_LEN = 16,
    parameter int unsigned RUN_WIDTH = 8
) (
    input  logic                 i_sys_clk,
    input  logic                 i_sys_rst,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_load,
    input  logic                 i_cmd_unload,
    input  logic [CHAIN_LEN-1:0] i_cmd_pattern,
    input  logic [RUN_WIDTH-1:0] i_cmd_run_cycles,
    input  logic                 i_abort,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [CHAIN_LEN-1:0] o_rsp_data,
    output logic                 o_scan_en,
    output logic                 o_scan_in,
    input  logic                 i_scan_out,
    output logic                 o_busy
);

    localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StShiftIn,
        StRun,
        StShiftOut,
        StResp
    } state_e;

    state_e                 state_q, state_d;
    logic [CHAIN_LEN-1:0]   pat_sr_q, pat_sr_d;
    logic [CHAIN_LEN-1:0]   cap_sr_q, cap_sr_d;
    logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [RUN_WIDTH-1:0]   run_cnt_q, run_cnt_d;
    logic                   unload_q, unload_d;

    always_comb begin
        state_d   = state_q;
        pat_sr_d  = pat_sr_q;
        cap_sr_d  = cap_sr_q;
        bit_cnt_d = bit_cnt_q;
        run_cnt_d = run_cnt_q;
        unload_d  = unload_q;

        unique case (state_q)
            StIdle: begin
                if (i_cmd_valid) begin
                    pat_sr_d  = i_cmd_pattern;
                    cap_sr_d  = '0;
                    bit_cnt_d = '0;
                    // Run counter is loaded here and left untouched until RUN is entered.
                    run_cnt_d = i_cmd_run_cycles;
                    unload_d  = i_cmd_unload;
                    if (i_cmd_load) begin
                        state_d = StShiftIn;
                    end else if (i_cmd_run_cycles != '0) begin
                        state_d = StRun;
                    end else if (i_cmd_unload) begin
                        state_d = StShiftOut;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StShiftIn: begin
                pat_sr_d  = pat_sr_q << 1;
                bit_cnt_d = bit_cnt_q + CntW'(1);
                if (bit_cnt_q == LastBit) begin
                    bit_cnt_d = '0;
                    if (run_cnt_q != '0) begin
                        state_d = StRun;
                    end else if (unload_q) begin
                        state_d = StShiftOut;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StRun: begin
                run_cnt_d = run_cnt_q - RUN_WIDTH'(1);
                if (run_cnt_q == RUN_WIDTH'(1)) begin
                    state_d = unload_q ? StShiftOut : StResp;
                end
            end
            StShiftOut: begin
                cap_sr_d  = {cap_sr_q[CHAIN_LEN-2:0], i_scan_out};
                bit_cnt_d = bit_cnt_q + CntW'(1);
                if (bit_cnt_q == LastBit) begin
                    bit_cnt_d = '0;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (i_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides everything, including a response handshake.
        if (i_abort && state_q != StIdle) begin
            state_d   = StIdle;
            pat_sr_d  = '0;
            cap_sr_d  = '0;
            bit_cnt_d = '0;
            run_cnt_d = '0;
            unload_d  = 1'b0;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q   <= StIdle;
            pat_sr_q  <= '0;
            cap_sr_q  <= '0;
            bit_cnt_q <= '0;
            run_cnt_q <= '0;
            unload_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_sr_q  <= pat_sr_d;
            cap_sr_q  <= cap_sr_d;
            bit_cnt_q <= bit_cnt_d;
            run_cnt_q <= run_cnt_d;
            unload_q  <= unload_d;
        end
    end

    assign o_cmd_ready = (state_q == StIdle);
    assign o_busy      = (state_q != StIdle);
    assign o_scan_en   = (state_q == StShiftIn) || (state_q == StShiftOut);
    assign o_scan_in   = (state_q == StShiftIn) && pat_sr_q[CHAIN_LEN-1];
    assign o_rsp_valid = (state_q == StResp);
    assign o_rsp_data  = (state_q == StResp && unload_q) ? cap_sr_q : '0;

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Bench for scan_seq_ctrl: a counter-style core model on the scan trio, directed and
// randomized commands checked against results derived from the command fields.
module tb_scan_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_load, cmd_unload;
    logic [15:0] cmd_pattern;
    logic [7:0]  cmd_run_cycles;
    logic        abort_i, rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        scan_en, scan_in, scan_out, busy;

    int checks = 0;
    int errors = 0;

    // Core model: 16-bit PC that counts only while the sequencer runs it functionally.
    logic [15:0] chain = '0;
    logic        chain_set = 1'b0;
    logic [15:0] chain_val = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (chain_set)                chain <= chain_val;
        else if (scan_en)             chain <= {chain[14:0], scan_in};
        else if (busy && !rsp_valid)  chain <= chain + 16'd1;
    end
    assign scan_out = chain[15];

    scan_seq_ctrl #(.CHAIN_LEN(16), .RUN_WIDTH(8)) dut (
        .i_sys_clk        (clk),
        .i_sys_rst        (rst),
        .i_cmd_valid      (cmd_valid),
        .o_cmd_ready      (cmd_ready),
        .i_cmd_load       (cmd_load),
        .i_cmd_unload     (cmd_unload),
        .i_cmd_pattern    (cmd_pattern),
        .i_cmd_run_cycles (cmd_run_cycles),
        .i_abort          (abort_i),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_data       (rsp_data),
        .o_scan_en        (scan_en),
        .o_scan_in        (scan_in),
        .i_scan_out       (scan_out),
        .o_busy           (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {cmd_ready, rsp_valid, rsp_data, scan_en, scan_in, busy},
              {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic issue(input logic ld, input logic ul, input logic [15:0] pat,
                         input int run, input logic [15:0] init);
        check("ready_before_cmd", cmd_ready, 1'b1);
        chain_set      = 1'b1;
        chain_val      = init;
        cmd_valid      = 1'b1;
        cmd_load       = ld;
        cmd_unload     = ul;
        cmd_pattern    = pat;
        cmd_run_cycles = 8'(run);
        step();
        cmd_valid = 1'b0;
        chain_set = 1'b0;
    endtask

    // Full command with response held off for `hold` cycles.
    task automatic run_cmd(input logic ld, input logic ul, input logic [15:0] pat,
                           input int run, input logic [15:0] init, input int hold);
        logic [15:0] base, exp_rsp, exp_chain, bits;
        int c, en_cnt, exp_lat;
        bit got;
        base      = ld ? pat : init;
        exp_chain = base + 16'(run);
        exp_rsp   = ul ? exp_chain : 16'h0;
        if (ul) exp_chain = 16'h0;
        exp_lat   = (ld ? 16 : 0) + run + (ul ? 16 : 0);
        issue(ld, ul, pat, run, init);
        c = 0; en_cnt = 0; bits = '0; got = 1'b0;
        while (c < 400) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (scan_en) begin
                en_cnt++;
                if (ld && en_cnt <= 16) bits = {bits[14:0], scan_in};
            end
            step();
            c++;
        end
        check("rsp_seen", 32'(got), 32'd1);
        check("latency", c, exp_lat);
        check("scan_en_cycles", en_cnt, (ld ? 16 : 0) + (ul ? 16 : 0));
        if (ld) check("scan_in_bits", bits, pat);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_data", rsp_data, exp_rsp);
            check("hold_not_ready", cmd_ready, 1'b0);
            step();
        end
        // A command offered on the handshake cycle must be ignored.
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        check("rsp_data", rsp_data, exp_rsp);
        step();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("idle_after_rsp", {busy, cmd_ready, rsp_valid}, 3'b010);
        step();
        check("no_accept_on_rsp_edge", busy, 1'b0);
        check("chain_after", chain, exp_chain);
    endtask

    // Abort after k cycles in the command; expects the controller back in IDLE next edge.
    task automatic abort_cmd(input logic ld, input logic ul, input logic [15:0] pat,
                             input int run, input int k);
        issue(ld, ul, pat, run, 16'h0);
        repeat (k) step();
        check("busy_before_abort", busy, 1'b1);
        abort_i = 1'b1;
        rsp_ready = 1'b1;
        step();
        abort_i = 1'b0;
        rsp_ready = 1'b0;
        check("after_abort", {busy, scan_en, rsp_valid, cmd_ready}, 4'b0001);
        repeat (3) begin
            step();
            check("no_rsp_after_abort", {rsp_valid, busy}, 2'b00);
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_load = 1'b0; cmd_unload = 1'b0;
        cmd_pattern = '0; cmd_run_cycles = '0;
        abort_i = 1'b0; rsp_ready = 1'b0;
        step();
        step();
        check_reset_outputs("reset_state");
        rst = 1'b0;
        step();

        run_cmd(1'b1, 1'b1, 16'h00AA, 10, 16'h0000, 0);
        run_cmd(1'b1, 1'b0, 16'h1234, 0, 16'h0000, 0);
        run_cmd(1'b0, 1'b1, 16'h0000, 0, 16'h0067, 0);
        abort_cmd(1'b1, 1'b1, 16'hBEEF, 5, 4);
        run_cmd(1'b1, 1'b1, 16'h5A5A, 3, 16'h0000, 0);
        run_cmd(1'b1, 1'b1, 16'hC3C3, 4, 16'h0000, 7);
        run_cmd(1'b0, 1'b0, 16'h0000, 0, 16'h0000, 1);

        // Reset during RUN.
        issue(1'b0, 1'b1, 16'h0000, 20, 16'h0100);
        repeat (5) step();
        rst = 1'b1;
        step();
        check_reset_outputs("reset_mid_run");
        rst = 1'b0;
        step();
        run_cmd(1'b0, 1'b1, 16'h0000, 2, 16'h0300, 0);

        for (int n = 0; n < 24; n++) begin
            logic ld, ul;
            int run, lat;
            ld  = 1'($urandom_range(0, 1));
            ul  = 1'($urandom_range(0, 1));
            run = $urandom_range(0, 20);
            lat = (ld ? 16 : 0) + run + (ul ? 16 : 0);
            if ($urandom_range(0, 3) == 0 && lat > 0)
                abort_cmd(ld, ul, 16'($urandom), run, $urandom_range(0, lat - 1));
            else
                run_cmd(ld, ul, 16'($urandom), run, 16'($urandom), $urandom_range(0, 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
